// File: rtl/hash_table_pkg.sv
// Shared hash-table types: result codes, data-RAM node layout and the delete-engine state encoding.
package hash_table;

  localparam int HT_KEY_WIDTH    = 32;
  localparam int HT_VALUE_WIDTH  = 32;
  localparam int HT_A_WIDTH      = 10;
  localparam int HT_BUCKET_WIDTH = 8;

  typedef enum logic [2:0] {
    LOOKUP_SUCCESS,
    LOOKUP_NOT_SUCCESS_NO_ENTRY,
    INSERT_SUCCESS,
    INSERT_SUCCESS_SAME_KEY,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL,
    DELETE_SUCCESS,
    DELETE_NOT_SUCCESS_NO_ENTRY,
    DELETE_CHAIN_ERROR
  } ht_rescode_t;

  typedef struct packed {
    logic [HT_KEY_WIDTH-1:0]   key;
    logic [HT_VALUE_WIDTH-1:0] value;
    logic [HT_A_WIDTH-1:0]     next_ptr;
    logic                      next_val;
  } ram_node_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_UNLINK,
    S_FREE,
    S_REPORT
  } del_state_t;

endpackage

// File: rtl/data_table_chain_delete_rd_wait_cnt.sv
// Read-latency down-counter: loaded on each RAM read, pulses data_vld_o in the cycle the read data is valid.
module rd_wait_cnt #(
  parameter int LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic data_vld_o
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= CW'(LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign data_vld_o = (cnt == CW'(1));

endmodule

// File: rtl/data_table_chain_delete.sv
// Hash-table delete engine: walks one bucket chain and unlinks/frees the first (or, in purge mode, every) matching key.
// Optional macro DATA_TABLE_DELETE_STATS_EN adds saturating task/deleted/error counters.
module data_table_chain_delete
  import hash_table::*;
#(
  parameter int KEY_WIDTH    = HT_KEY_WIDTH,
  parameter int VALUE_WIDTH  = HT_VALUE_WIDTH,
  parameter int A_WIDTH      = HT_A_WIDTH,
  parameter int BUCKET_WIDTH = HT_BUCKET_WIDTH,
  parameter int RAM_LATENCY  = 2,
  parameter int MAX_HOPS     = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [KEY_WIDTH-1:0]             task_key_i,
  input  logic [BUCKET_WIDTH-1:0]          task_bucket_i,
  input  logic [A_WIDTH-1:0]               task_head_ptr_i,
  input  logic                             task_head_val_i,
  input  logic                             task_purge_i,
  input  logic                             task_valid_i,
  output logic                             task_ready_o,
  output logic                             rd_en_o,
  output logic [A_WIDTH-1:0]               rd_addr_o,
  input  logic [KEY_WIDTH-1:0]             rd_key_i,
  input  logic [VALUE_WIDTH-1:0]           rd_value_i,
  input  logic [A_WIDTH-1:0]               rd_next_ptr_i,
  input  logic                             rd_next_val_i,
  output logic                             wr_en_o,
  output logic [A_WIDTH-1:0]               wr_addr_o,
  output logic [KEY_WIDTH-1:0]             wr_key_o,
  output logic [VALUE_WIDTH-1:0]           wr_value_o,
  output logic [A_WIDTH-1:0]               wr_next_ptr_o,
  output logic                             wr_next_val_o,
  output logic                             head_wr_en_o,
  output logic [BUCKET_WIDTH-1:0]          head_wr_addr_o,
  output logic [A_WIDTH-1:0]               head_wr_ptr_o,
  output logic                             head_wr_val_o,
  output logic                             free_ptr_en_o,
  output logic [A_WIDTH-1:0]               free_ptr_o,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output ht_rescode_t                      res_rescode_o,
  output logic [KEY_WIDTH-1:0]             res_key_o,
  output logic [BUCKET_WIDTH-1:0]          res_bucket_o,
  output logic [$clog2(MAX_HOPS+1)-1:0]    res_del_cnt_o
`ifdef DATA_TABLE_DELETE_STATS_EN
  ,
  output logic [31:0]                      stat_tasks_o,
  output logic [31:0]                      stat_deleted_o,
  output logic [31:0]                      stat_errors_o
`endif
);

  localparam int CNT_W = $clog2(MAX_HOPS + 1);

  del_state_t state, state_nxt;

  logic [KEY_WIDTH-1:0]    t_key;
  logic [BUCKET_WIDTH-1:0] t_bucket;
  logic                    t_purge;
  logic [A_WIDTH-1:0]      cur;
  logic [A_WIDTH-1:0]      nxt_ptr;
  logic                    nxt_val;
  logic [A_WIDTH-1:0]      prev_addr;
  ram_node_t               prev_node;
  logic                    prev_val;
  logic [CNT_W-1:0]        hops;
  logic [CNT_W-1:0]        del_cnt;
  logic                    aborted;
  logic                    rd_dat_vld;
  logic                    key_hit;
  logic                    hops_at_limit;

  rd_wait_cnt #(.LATENCY(RAM_LATENCY)) u_rd_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (rd_en_o),
    .data_vld_o (rd_dat_vld)
  );

  assign key_hit       = (rd_key_i == t_key);
  assign hops_at_limit = (hops >= CNT_W'(MAX_HOPS));

  assign rd_addr_o      = cur;
  assign free_ptr_o     = cur;
  assign head_wr_addr_o = t_bucket;
  assign head_wr_ptr_o  = nxt_ptr;
  assign head_wr_val_o  = nxt_val;
  assign res_key_o      = t_key;
  assign res_bucket_o   = t_bucket;
  assign res_del_cnt_o  = del_cnt;
  assign res_rescode_o  = aborted          ? DELETE_CHAIN_ERROR :
                          (del_cnt != '0)  ? DELETE_SUCCESS     : DELETE_NOT_SUCCESS_NO_ENTRY;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    task_ready_o  = 1'b0;
    rd_en_o       = 1'b0;
    wr_en_o       = 1'b0;
    wr_addr_o     = '0;
    wr_key_o      = '0;
    wr_value_o    = '0;
    wr_next_ptr_o = '0;
    wr_next_val_o = 1'b0;
    head_wr_en_o  = 1'b0;
    free_ptr_en_o = 1'b0;
    res_valid_o   = 1'b0;
    case (state)
      S_IDLE: begin
        task_ready_o = 1'b1;
        if (task_valid_i) state_nxt = task_head_val_i ? S_READ : S_REPORT;
      end
      S_READ: begin
        if (hops_at_limit) begin
          state_nxt = S_REPORT;
        end else begin
          rd_en_o   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_dat_vld) begin
          if (key_hit)            state_nxt = S_UNLINK;
          else if (rd_next_val_i) state_nxt = S_READ;
          else                    state_nxt = S_REPORT;
        end
      end
      S_UNLINK: begin
        // prev_node already carries the deleted node's successor as its next link
        if (!prev_val) begin
          head_wr_en_o = 1'b1;
        end else begin
          wr_en_o       = 1'b1;
          wr_addr_o     = prev_addr;
          wr_key_o      = prev_node.key;
          wr_value_o    = prev_node.value;
          wr_next_ptr_o = prev_node.next_ptr;
          wr_next_val_o = prev_node.next_val;
        end
        state_nxt = S_FREE;
      end
      S_FREE: begin
        wr_en_o       = 1'b1;
        wr_addr_o     = cur;
        free_ptr_en_o = 1'b1;
        state_nxt     = (t_purge && nxt_val) ? S_READ : S_REPORT;
      end
      S_REPORT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      t_key     <= '0;
      t_bucket  <= '0;
      t_purge   <= 1'b0;
      cur       <= '0;
      nxt_ptr   <= '0;
      nxt_val   <= 1'b0;
      prev_addr <= '0;
      prev_node <= '0;
      prev_val  <= 1'b0;
      hops      <= '0;
      del_cnt   <= '0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (task_valid_i) begin
            t_key    <= task_key_i;
            t_bucket <= task_bucket_i;
            t_purge  <= task_purge_i;
            cur      <= task_head_ptr_i;
            prev_val <= 1'b0;
            hops     <= '0;
            del_cnt  <= '0;
            aborted  <= 1'b0;
          end
        end
        S_READ: begin
          if (hops_at_limit) aborted <= 1'b1;
          else               hops    <= hops + 1'b1;
        end
        S_WAIT: begin
          if (rd_dat_vld) begin
            nxt_ptr <= rd_next_ptr_i;
            nxt_val <= rd_next_val_i;
            if (key_hit) begin
              prev_node.next_ptr <= rd_next_ptr_i;
              prev_node.next_val <= rd_next_val_i;
            end else begin
              prev_addr <= cur;
              prev_node <= '{key: rd_key_i, value: rd_value_i,
                             next_ptr: rd_next_ptr_i, next_val: rd_next_val_i};
              prev_val  <= 1'b1;
              if (rd_next_val_i) cur <= rd_next_ptr_i;
            end
          end
        end
        S_FREE: begin
          del_cnt <= del_cnt + 1'b1;
          if (t_purge && nxt_val) cur <= nxt_ptr;
        end
        default: ;
      endcase
    end
  end

`ifdef DATA_TABLE_DELETE_STATS_EN
  logic        res_fire;
  logic [32:0] deleted_sum;

  assign res_fire    = res_valid_o && res_ready_i;
  assign deleted_sum = {1'b0, stat_deleted_o} + 33'(del_cnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_tasks_o   <= '0;
      stat_deleted_o <= '0;
      stat_errors_o  <= '0;
    end else if (res_fire) begin
      if (stat_tasks_o != '1) stat_tasks_o <= stat_tasks_o + 1'b1;
      stat_deleted_o <= deleted_sum[32] ? '1 : deleted_sum[31:0];
      if (aborted && stat_errors_o != '1) stat_errors_o <= stat_errors_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_table_chain_delete.sv
// Bench for data_table_chain_delete: RAM/head-table environment, chain-walk reference model, event scoreboard.
`timescale 1ns/1ps
module tb_data_table_chain_delete;
  import hash_table::*;

  localparam int LAT  = 2;
  localparam int MAXH = 4;
  localparam int CW   = $clog2(MAXH + 1);
  localparam int EV_RD = 1, EV_HD = 2, EV_WR = 3, EV_FR = 4;

  typedef struct packed { logic val; logic [9:0] ptr; } head_t;
  typedef struct { int kind; int addr; ram_node_t data; } ev_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [31:0] task_key_i = '0;
  logic [7:0]  task_bucket_i = '0;
  logic [9:0]  task_head_ptr_i = '0;
  logic        task_head_val_i = 1'b0, task_purge_i = 1'b0, task_valid_i = 1'b0;
  logic        task_ready_o, rd_en_o;
  logic [9:0]  rd_addr_o;
  logic [31:0] rd_key_i, rd_value_i;
  logic [9:0]  rd_next_ptr_i;
  logic        rd_next_val_i;
  logic        wr_en_o;
  logic [9:0]  wr_addr_o;
  logic [31:0] wr_key_o, wr_value_o;
  logic [9:0]  wr_next_ptr_o;
  logic        wr_next_val_o, head_wr_en_o;
  logic [7:0]  head_wr_addr_o;
  logic [9:0]  head_wr_ptr_o;
  logic        head_wr_val_o, free_ptr_en_o;
  logic [9:0]  free_ptr_o;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  ht_rescode_t res_rescode_o;
  logic [31:0] res_key_o;
  logic [7:0]  res_bucket_o;
  logic [CW-1:0] res_del_cnt_o;

  data_table_chain_delete #(.RAM_LATENCY(LAT), .MAX_HOPS(MAXH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .task_key_i(task_key_i), .task_bucket_i(task_bucket_i), .task_head_ptr_i(task_head_ptr_i),
    .task_head_val_i(task_head_val_i), .task_purge_i(task_purge_i), .task_valid_i(task_valid_i),
    .task_ready_o(task_ready_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_key_i(rd_key_i), .rd_value_i(rd_value_i), .rd_next_ptr_i(rd_next_ptr_i), .rd_next_val_i(rd_next_val_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_key_o(wr_key_o), .wr_value_o(wr_value_o),
    .wr_next_ptr_o(wr_next_ptr_o), .wr_next_val_o(wr_next_val_o),
    .head_wr_en_o(head_wr_en_o), .head_wr_addr_o(head_wr_addr_o), .head_wr_ptr_o(head_wr_ptr_o),
    .head_wr_val_o(head_wr_val_o), .free_ptr_en_o(free_ptr_en_o), .free_ptr_o(free_ptr_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_rescode_o(res_rescode_o),
    .res_key_o(res_key_o), .res_bucket_o(res_bucket_o), .res_del_cnt_o(res_del_cnt_o)
  );

  // Environment: data RAM with LAT-cycle read pipe and head table, plus a backdoor for chain setup
  ram_node_t mem [1024];
  head_t     head_tab [256];
  ram_node_t pipe [LAT];
  logic      bd_node_en = 1'b0, bd_head_en = 1'b0;
  logic [9:0] bd_addr = '0;
  logic [7:0] bd_bucket = '0;
  ram_node_t bd_node = '0;
  head_t     bd_head = '0;

  always @(posedge clk_i) begin
    pipe[0] <= rd_en_o ? mem[rd_addr_o] : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (wr_en_o)      mem[wr_addr_o] <= '{key: wr_key_o, value: wr_value_o, next_ptr: wr_next_ptr_o, next_val: wr_next_val_o};
    if (head_wr_en_o) head_tab[head_wr_addr_o] <= '{val: head_wr_val_o, ptr: head_wr_ptr_o};
    if (bd_node_en)   mem[bd_addr] <= bd_node;
    if (bd_head_en)   head_tab[bd_bucket] <= bd_head;
  end
  assign rd_key_i      = pipe[LAT-1].key;
  assign rd_value_i    = pipe[LAT-1].value;
  assign rd_next_ptr_i = pipe[LAT-1].next_ptr;
  assign rd_next_val_i = pipe[LAT-1].next_val;

  int n_checks = 0, n_pass = 0;
  ev_t exp_q[$];
  int  obs_free[$];
  int  obs_reads = 0, exp_reads = 0, exp_cnt = 0;
  ht_rescode_t exp_code = DELETE_NOT_SUCCESS_NO_ENTRY;
  logic [31:0] exp_key = '0;
  logic [7:0]  exp_bucket = '0;
  ht_rescode_t got_code;
  int          got_cnt;
  int ca[8], ck[8];

  function automatic void check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void mon_ev(input int kind, input int addr, input ram_node_t d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_event_kind", kind, 0);
    end else begin
      e = exp_q.pop_front();
      check_eq("ev_kind", kind, e.kind);
      check_eq("ev_addr", addr, e.addr);
      check_eq("ev_data", d, e.data);
    end
  endfunction

  // Compare process: every DUT side effect must match the model's event list, results checked while valid
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rd_en_o) begin
        obs_reads++;
        mon_ev(EV_RD, int'(rd_addr_o), '0);
      end
      if (head_wr_en_o) mon_ev(EV_HD, int'(head_wr_addr_o), ram_node_t'({64'h0, head_wr_ptr_o, head_wr_val_o}));
      if (wr_en_o) mon_ev(EV_WR, int'(wr_addr_o), ram_node_t'({wr_key_o, wr_value_o, wr_next_ptr_o, wr_next_val_o}));
      if (free_ptr_en_o) begin
        obs_free.push_back(int'(free_ptr_o));
        mon_ev(EV_FR, int'(free_ptr_o), '0);
      end
      if (head_wr_en_o || wr_en_o) check_eq("single_write", head_wr_en_o & wr_en_o, 0);
      if (res_valid_o) begin
        check_eq("res_code", res_rescode_o, exp_code);
        check_eq("res_cnt", res_del_cnt_o, exp_cnt);
        check_eq("res_key", res_key_o, exp_key);
        check_eq("res_bucket", res_bucket_o, exp_bucket);
      end
    end
  end

  // Reference model: walk the chain on a copy of the table, listing the expected side effects in order
  task automatic model_task(input logic [31:0] key, input int bucket, input bit purge);
    ram_node_t m [1024];
    ram_node_t nd, z, hd;
    int cur, prev, hops;
    bit walking, abort;
    m = mem;
    z = '0;
    exp_q.delete();
    exp_cnt = 0; hops = 0; prev = -1; abort = 0;
    walking = head_tab[bucket].val;
    cur = int'(head_tab[bucket].ptr);
    while (walking) begin
      if (hops >= MAXH) begin abort = 1; break; end
      exp_q.push_back('{EV_RD, cur, z});
      hops++;
      nd = m[cur];
      if (nd.key == key) begin
        if (prev < 0) begin
          hd = '0; hd.next_ptr = nd.next_ptr; hd.next_val = nd.next_val;
          exp_q.push_back('{EV_HD, bucket, hd});
        end else begin
          m[prev].next_ptr = nd.next_ptr;
          m[prev].next_val = nd.next_val;
          exp_q.push_back('{EV_WR, prev, m[prev]});
        end
        exp_q.push_back('{EV_WR, cur, z});
        exp_q.push_back('{EV_FR, cur, z});
        m[cur] = z;
        exp_cnt++;
        walking = purge && nd.next_val;
      end else begin
        prev = cur;
        walking = nd.next_val;
      end
      cur = int'(nd.next_ptr);
    end
    exp_reads  = hops;
    exp_code   = abort ? DELETE_CHAIN_ERROR : (exp_cnt > 0 ? DELETE_SUCCESS : DELETE_NOT_SUCCESS_NO_ENTRY);
    exp_key    = key;
    exp_bucket = 8'(bucket);
  endtask

  task automatic poke_node(input int a, input ram_node_t n);
    bd_addr = 10'(a); bd_node = n; bd_node_en = 1'b1;
    @(posedge clk_i); #1 bd_node_en = 1'b0;
  endtask

  task automatic poke_head(input int b, input head_t h);
    bd_bucket = 8'(b); bd_head = h; bd_head_en = 1'b1;
    @(posedge clk_i); #1 bd_head_en = 1'b0;
  endtask

  // Chain from ca[0..len-1] with keys ck[]; cyclic closes the last node back onto the first
  task automatic build_chain(input int bucket, input int len, input bit cyclic);
    ram_node_t n;
    for (int i = 0; i < len; i++) begin
      n.key   = 32'(ck[i]);
      n.value = 32'h1000 + 32'(ca[i]);
      if (i < len - 1) begin
        n.next_ptr = 10'(ca[i+1]); n.next_val = 1'b1;
      end else begin
        n.next_ptr = cyclic ? 10'(ca[0]) : 10'd0; n.next_val = cyclic;
      end
      poke_node(ca[i], n);
    end
    poke_head(bucket, '{val: 1'b1, ptr: 10'(ca[0])});
  endtask

  task automatic run_task(input logic [31:0] key, input int bucket, input bit purge, input int hold);
    int w;
    model_task(key, bucket, purge);
    obs_reads = 0;
    obs_free.delete();
    task_key_i = key; task_bucket_i = 8'(bucket); task_purge_i = purge;
    task_head_ptr_i = head_tab[bucket].ptr; task_head_val_i = head_tab[bucket].val;
    task_valid_i = 1'b1;
    @(posedge clk_i); #1 task_valid_i = 1'b0;
    w = 0;
    while (!res_valid_o && w < 200) begin @(posedge clk_i); #1 w++; end
    check_eq("res_timeout", res_valid_o, 1);
    got_code = res_rescode_o;
    got_cnt  = int'(res_del_cnt_o);
    for (int i = 0; i < hold; i++) begin
      check_eq("ready_low_in_report", task_ready_o, 0);
      @(posedge clk_i); #1;
      check_eq("res_held", res_valid_o, 1);
    end
    res_ready_i = 1'b1;
    @(posedge clk_i); #1 res_ready_i = 1'b0;
    check_eq("events_drained", exp_q.size(), 0);
    check_eq("read_count", obs_reads, exp_reads);
    check_eq("back_to_idle", {task_ready_o, res_valid_o}, 2'b10);
  endtask

  task automatic check_quiet(input string name);
    check_eq(name, {task_ready_o, rd_en_o, wr_en_o, head_wr_en_o, free_ptr_en_o, res_valid_o}, 6'b100000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, len, base;
    bit cyc, purge;
    #1 check_quiet("reset_state");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // 1: empty bucket
    poke_head(0, '0);
    run_task(32'h11, 0, 1'b0, 0);
    check_eq("t1_model_code", exp_code, DELETE_NOT_SUCCESS_NO_ENTRY);
    check_eq("t1_code", got_code, DELETE_NOT_SUCCESS_NO_ENTRY);
    check_eq("t1_cnt", got_cnt, 0);
    check_eq("t1_reads", obs_reads, 0);

    // 2: delete head of 5(A)->9(B)
    ca = '{5, 9, 0, 0, 0, 0, 0, 0}; ck = '{'hA, 'hB, 0, 0, 0, 0, 0, 0};
    build_chain(1, 2, 1'b0);
    run_task(32'hA, 1, 1'b0, 0);
    check_eq("t2_code", got_code, DELETE_SUCCESS);
    check_eq("t2_cnt", got_cnt, 1);
    check_eq("t2_head", head_tab[1], 11'h409);
    check_eq("t2_zero5", mem[5], 0);
    check_eq("t2_free", obs_free.size() == 1 ? obs_free[0] : -1, 5);

    // 3: delete tail of the same chain
    build_chain(1, 2, 1'b0);
    run_task(32'hB, 1, 1'b0, 0);
    check_eq("t3_code", got_code, DELETE_SUCCESS);
    check_eq("t3_link5", {mem[5].key, mem[5].next_val}, {32'hA, 1'b0});
    check_eq("t3_free", obs_free.size() == 1 ? obs_free[0] : -1, 9);

    // 4: purge A on 3(A)->4(A)->7(C)->8(A)
    ca = '{3, 4, 7, 8, 0, 0, 0, 0}; ck = '{'hA, 'hA, 'hC, 'hA, 0, 0, 0, 0};
    build_chain(2, 4, 1'b0);
    run_task(32'hA, 2, 1'b1, 0);
    check_eq("t4_cnt", got_cnt, 3);
    check_eq("t4_model_cnt", exp_cnt, 3);
    check_eq("t4_head", head_tab[2], 11'h407);
    check_eq("t4_link7", mem[7].next_val, 0);
    check_eq("t4_frees", obs_free.size() == 3 ? {obs_free[0], obs_free[1], obs_free[2]} : 0, {32'd3, 32'd4, 32'd8});

    // 5: cyclic 2->6->2, no match
    ca = '{2, 6, 0, 0, 0, 0, 0, 0}; ck = '{'h1, 'h2, 0, 0, 0, 0, 0, 0};
    build_chain(3, 2, 1'b1);
    run_task(32'h55, 3, 1'b0, 0);
    check_eq("t5_code", got_code, DELETE_CHAIN_ERROR);
    check_eq("t5_reads", obs_reads, 4);

    // 6: result held under backpressure, then reset mid-walk
    ca = '{20, 21, 0, 0, 0, 0, 0, 0}; ck = '{'h1, 'h2, 0, 0, 0, 0, 0, 0};
    build_chain(4, 2, 1'b0);
    run_task(32'h2, 4, 1'b0, 10);
    build_chain(4, 2, 1'b0);
    model_task(32'h2, 4, 1'b0);
    task_key_i = 32'h2; task_bucket_i = 8'd4; task_purge_i = 1'b0;
    task_head_ptr_i = head_tab[4].ptr; task_head_val_i = 1'b1; task_valid_i = 1'b1;
    @(posedge clk_i); #1 task_valid_i = 1'b0;
    w = 0;
    while (!rd_en_o && w < 20) begin @(posedge clk_i); #1 w++; end
    check_eq("t6_read_seen", rd_en_o, 1);
    @(posedge clk_i); #1 rst_i = 1'b1;
    #1 check_quiet("t6_reset_async");
    exp_q.delete();
    @(posedge clk_i); #1 check_quiet("t6_reset_next");
    rst_i = 1'b0;
    run_task(32'h2, 4, 1'b0, 0);
    check_eq("t6_recover_code", got_code, DELETE_SUCCESS);

    // Randomised chains, keys and modes
    for (int it = 0; it < 40; it++) begin
      len  = int'($urandom_range(1, 5));
      base = int'($urandom_range(0, 900));
      cyc  = ($urandom_range(0, 4) == 0);
      purge = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 8; i++) begin
        ca[i] = base + i * 7;
        ck[i] = int'($urandom_range(1, 3));
      end
      build_chain(8 + it, len, cyc);
      if ($urandom_range(0, 7) == 0) poke_head(8 + it, '0);
      run_task(32'($urandom_range(1, 4)), 8 + it, purge, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
